// File: rtl/booth_seq_multiply_if.sv
`default_nettype none
// ============================================================================
// Module   : booth_seq_multiply_if
// Purpose  : Start/busy/done handshake and operand/product bus for the
//            sequential Booth multiplier.
// Revision : 1.0 - initial release
// ============================================================================
interface booth_seq_multiply_if #(
    parameter int BITS = 32
);
    logic                start;
    logic                is_signed;
    logic [BITS-1:0]     multiplicand;
    logic [BITS-1:0]     multiplier;
    logic                busy;
    logic                done;
    logic [2*BITS-1:0]   product;

    modport master (
        output start, is_signed, multiplicand, multiplier,
        input  busy, done, product
    );

    modport slave (
        input  start, is_signed, multiplicand, multiplier,
        output busy, done, product
    );
endinterface
`default_nettype wire

// File: rtl/booth_seq_multiply.sv
`default_nettype none
// ============================================================================
// Module   : booth_seq_multiply
// Purpose  : Iterative radix-4 Booth multiplier, one 3-bit group per clock,
//            signed/unsigned mode. Optional EARLY_TERM_EN macro ends the run
//            once the remaining multiplier bits are pure sign extension.
// Revision : 1.0 - initial release
// ============================================================================
module booth_seq_multiply #(
    parameter int BITS = 32
) (
    input  wire logic           clk,
    input  wire logic           reset,
    booth_seq_multiply_if.slave bus
);
    localparam int EXT_W = BITS + 2;
    localparam int ACC_W = 2*BITS + 4;
    localparam int CNT_W = $clog2(BITS/2 + 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   a_q, a_d;
    logic [EXT_W:0]     m_q, m_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   last_q, last_d;
    logic [2*BITS-1:0]  prod_q, prod_d;

    logic [ACC_W-1:0]   w_pp;
    logic [ACC_W-1:0]   w_acc_sum;
    logic               w_rest_uniform;
    logic               w_ext_m;

    // a_q carries A << 2j and m_q the multiplier (with m[-1]) shifted right by
    // 2j, so the current group always sits at m_q[2:0].
    always_comb begin
        w_pp = '0;
        case (m_q[2:0])
            3'b001, 3'b010: w_pp = a_q;
            3'b011:         w_pp = a_q << 1;
            3'b100:         w_pp = -(a_q << 1);
            3'b101, 3'b110: w_pp = -a_q;
            default:        w_pp = '0;
        endcase
    end

    assign w_acc_sum = acc_q + w_pp;
    assign w_ext_m   = bus.is_signed & bus.multiplier[BITS-1];

`ifdef EARLY_TERM_EN
    assign w_rest_uniform = (&m_q[EXT_W:2]) | ~(|m_q[EXT_W:2]);
`else
    assign w_rest_uniform = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        m_d     = m_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        prod_d  = prod_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    a_d     = bus.is_signed
                              ? {{(ACC_W-BITS){bus.multiplicand[BITS-1]}}, bus.multiplicand}
                              : {{(ACC_W-BITS){1'b0}}, bus.multiplicand};
                    m_d     = {w_ext_m, w_ext_m, bus.multiplier, 1'b0};
                    acc_d   = '0;
                    cnt_d   = '0;
                    last_d  = bus.is_signed ? CNT_W'(BITS/2 - 1) : CNT_W'(BITS/2);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                acc_d = w_acc_sum;
                a_d   = a_q << 2;
                m_d   = {m_q[EXT_W], m_q[EXT_W], m_q[EXT_W:2]};
                cnt_d = cnt_q + CNT_W'(1);
                if ((cnt_q == last_q) || w_rest_uniform) begin
                    state_d = S_DONE;
                    prod_d  = w_acc_sum[2*BITS-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            m_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            last_q  <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            prod_q  <= prod_d;
        end
    end

    assign bus.busy    = (state_q == S_RUN);
    assign bus.done    = (state_q == S_DONE);
    assign bus.product = prod_q;
endmodule
`default_nettype wire

// File: tb/tb_booth_seq_multiply.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_seq_multiply
// Purpose  : Self-checking bench for booth_seq_multiply (BITS=32), directed
//            cases plus randomized operands against an arithmetic reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_booth_seq_multiply;
    localparam int BITS = 32;
`ifdef EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    booth_seq_multiply_if #(.BITS(BITS)) bus();

    booth_seq_multiply #(.BITS(BITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(input bit sg, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb;
        ea = sg ? {{32{a[31]}}, a} : {32'b0, a};
        eb = sg ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    // Cycles from accept to done: full group count, or the first group after
    // which the rest of the extended multiplier is uniform.
    function automatic int exp_lat(input bit sg, input logic [31:0] b);
        int n;
        logic signed [33:0] e, rest;
        n = sg ? BITS/2 : BITS/2 + 1;
        e = sg ? {{2{b[31]}}, b} : {2'b00, b};
        for (int j = 0; j < n; j++) begin
            rest = e >>> (2*j + 1);
            if (EARLY && (rest == 0 || rest == -1)) return j + 1;
        end
        return n;
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] tbl [5];
        tbl[0] = 32'h0; tbl[1] = 32'h1; tbl[2] = 32'hFFFF_FFFF;
        tbl[3] = 32'h8000_0000; tbl[4] = 32'h7FFF_FFFF;
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return 32'($urandom_range(0, 15));
            2: return -32'($urandom_range(0, 15));
            default: return tbl[$urandom_range(0, 4)];
        endcase
    endfunction

    // Called at a sampling point; presents the request across one rising edge.
    task automatic launch(input bit sg, input logic [31:0] a, input logic [31:0] b);
        bus.start        = 1'b1;
        bus.is_signed    = sg;
        bus.multiplicand = a;
        bus.multiplier   = b;
        @(posedge clk); #1;
        bus.start        = 1'b0;
        bus.is_signed    = 1'($urandom);
        bus.multiplicand = $urandom;
        bus.multiplier   = $urandom;
    endtask

    task automatic finish_op(input string tag, input logic [63:0] exp_p, input int exp_n, input int inject_at);
        int cyc = 0;
        bit seen = 1'b0;
        bit busy_ok = 1'b1;
        while (!seen && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            bus.start = 1'b0;
            if (bus.done) begin
                seen = 1'b1;
            end else begin
                if (!bus.busy) busy_ok = 1'b0;
                if (cyc == inject_at) begin
                    bus.start        = 1'b1;
                    bus.is_signed    = 1'($urandom);
                    bus.multiplicand = $urandom;
                    bus.multiplier   = $urandom;
                end
            end
        end
        chk({tag, "_done"}, 64'(seen), 64'd1);
        chk({tag, "_lat"}, 64'(cyc), 64'(exp_n));
        chk({tag, "_prod"}, bus.product, exp_p);
        chk({tag, "_busy_run"}, 64'(busy_ok), 64'd1);
        chk({tag, "_busy_done"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        bit sg;
        bit saw_done;
        logic [31:0] a, b;

        bus.start = 1'b0; bus.is_signed = 1'b0;
        bus.multiplicand = '0; bus.multiplier = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_prod", bus.product, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        launch(1'b1, 32'd7, -32'sd3);
        finish_op("s7xm3", 64'hFFFF_FFFF_FFFF_FFEB, exp_lat(1'b1, -32'sd3), 0);
        @(posedge clk); #1;
        chk("done_pulse", 64'(bus.done), 64'd0);

        launch(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        finish_op("uff", 64'hFFFF_FFFE_0000_0001, exp_lat(1'b0, 32'hFFFF_FFFF), 0);
        @(posedge clk); #1;

        launch(1'b1, 32'h8000_0000, 32'h8000_0000);
        finish_op("smin2", 64'h4000_0000_0000_0000, exp_lat(1'b1, 32'h8000_0000), 0);
        launch(1'b1, 32'h0001_2345, 32'hFFFF_0007);
        finish_op("b2b", ref_prod(1'b1, 32'h0001_2345, 32'hFFFF_0007), exp_lat(1'b1, 32'hFFFF_0007), 0);

        @(posedge clk); #1;
        launch(1'b1, 32'h1234_5678, 32'h6543_210F);
        finish_op("ignore", ref_prod(1'b1, 32'h1234_5678, 32'h6543_210F), exp_lat(1'b1, 32'h6543_210F), 5);

        launch(1'b1, 32'd5, 32'd3);
        finish_op("s5x3", 64'd15, exp_lat(1'b1, 32'd3), 0);
        launch(1'b1, 32'd5, 32'hFFFF_FFFF);
        finish_op("s5xm1", 64'hFFFF_FFFF_FFFF_FFFB, exp_lat(1'b1, 32'hFFFF_FFFF), 0);

        for (int i = 0; i < 40; i++) begin
            sg = 1'($urandom_range(0, 1));
            a = pick();
            b = pick();
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            launch(sg, a, b);
            finish_op("rnd", ref_prod(sg, a, b), exp_lat(sg, b), 0);
        end

        launch(1'b1, 32'h1234_5678, 32'h6543_210F);
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_done", 64'(bus.done), 64'd0);
        chk("midrst_prod", bus.product, 64'd0);
        saw_done = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) saw_done = 1'b1;
        end
        chk("midrst_quiet", 64'(saw_done), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
